// File: rtl/router_pkt_gen_pkg.sv
// Shared definitions for the router packet generator: FSM encoding, field widths,
// payload buffer geometry and inter-packet gap length.
package router_pkt_gen_pkg;

    localparam int MAX_LEN    = 63;
    localparam int GAP_CYCLES = 2;
    localparam int BUF_DEPTH  = MAX_LEN + 1;
    localparam int BYTE_W     = 8;
    localparam int LEN_W      = 6;
    localparam int DEST_W     = 2;
    localparam int PTR_W      = 6;
    localparam int GAP_W      = 2;

    localparam logic [DEST_W-1:0] DEST_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

endpackage

// File: rtl/router_pkt_buf.sv
// 64x8 payload store with one write and one read port; both pointers
// advance per access and can be cleared together at the start of a packet.
module router_pkt_buf
    import router_pkt_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic [PTR_W-1:0]  wr_ptr,
    output logic [PTR_W-1:0]  rd_ptr
);

    logic [BYTE_W-1:0] mem [BUF_DEPTH];

    always_ff @(posedge clk) begin
        if (rstn || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // NOTE: the storage array has no reset; every byte read is written first
    // in the same packet, so clearing it would only cost flops.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/router_pkt_gen.sv
// Router packet generator: accepts a command, buffers the payload, then emits
// header, payload and parity bytes on a back-pressured router bus.
module router_pkt_gen
    import router_pkt_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    input  logic [DEST_W-1:0] cmd_dest,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_bad_par,
    output logic              cmd_ready,
    input  logic              s_valid,
    input  logic [BYTE_W-1:0] s_data,
    output logic              s_ready,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [BYTE_W-1:0] data_out,
    output logic              cmd_err,
    output logic              pkt_done
);

    state_t              state_q, state_d;
    logic [DEST_W-1:0]   dest_q;
    logic [LEN_W-1:0]    len_q;
    logic                bad_q;
    logic [BYTE_W-1:0]   par_q, par_d;
    logic [BYTE_W-1:0]   data_d;
    logic                valid_d, cmd_err_d, pkt_done_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                latch_cmd, buf_clr, wr_en, rd_en;
    logic [BYTE_W-1:0]   rd_data;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;

    router_pkt_buf u_buf (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (buf_clr),
        .wr_en   (wr_en),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr)
    );

    assign cmd_ready = (state_q == IDLE);
    assign s_ready   = (state_q == LOAD) && (wr_ptr < len_q);

    // NOTE: every signal gets its hold/idle value first so that no branch
    // below can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        data_d     = data_out;
        valid_d    = pkt_valid;
        par_d      = par_q;
        gap_d      = gap_q;
        cmd_err_d  = 1'b0;
        pkt_done_d = 1'b0;
        latch_cmd  = 1'b0;
        buf_clr    = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_dest == DEST_ILLEGAL || cmd_len == '0) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        latch_cmd = 1'b1;
                        buf_clr   = 1'b1;
                        state_d   = LOAD;
                    end
                end
            end
            LOAD: begin
                if (s_valid && s_ready) begin
                    wr_en = 1'b1;
                    if (wr_ptr == len_q - LEN_W'(1)) begin
                        state_d = HEADER;
                        data_d  = {len_q, dest_q};
                        valid_d = 1'b1;
                        par_d   = '0;
                    end
                end
            end
            HEADER: begin
                if (!busy) begin
                    par_d   = par_q ^ data_out;
                    data_d  = rd_data;
                    rd_en   = 1'b1;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!busy) begin
                    par_d = par_q ^ data_out;
                    // rd_ptr already points past the byte on the bus
                    if (rd_ptr == len_q) begin
                        state_d = PARITY;
                        valid_d = 1'b0;
                        data_d  = par_q ^ data_out ^ {BYTE_W{bad_q}};
                    end else begin
                        data_d = rd_data;
                        rd_en  = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    pkt_done_d = 1'b1;
                    data_d     = '0;
                    gap_d      = '0;
                    state_d    = GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = IDLE;
                else                                 gap_d   = gap_q + GAP_W'(1);
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= IDLE;
            pkt_valid <= 1'b0;
            data_out  <= '0;
            cmd_err   <= 1'b0;
            pkt_done  <= 1'b0;
            par_q     <= '0;
            gap_q     <= '0;
            dest_q    <= '0;
            len_q     <= '0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pkt_valid <= valid_d;
            data_out  <= data_d;
            cmd_err   <= cmd_err_d;
            pkt_done  <= pkt_done_d;
            par_q     <= par_d;
            gap_q     <= gap_d;
            if (latch_cmd) begin
                dest_q <= cmd_dest;
                len_q  <= cmd_len;
                bad_q  <= cmd_bad_par;
            end
        end
    end

endmodule

// File: doc/router_pkt_gen.md
ROUTER_PKT_GEN -- requirements
Module: router_pkt_gen

Interface
REQ-001 SHALL expose: clk  input  1  single system clock, all logic on rising edge.
REQ-002 SHALL expose: rstn  input  1  synchronous, active-high reset (high = reset, sampled on clk rising edge).
REQ-003 SHALL expose: cmd_valid  input  1  packet command offered.
REQ-004 SHALL expose: cmd_dest  input  2  destination port, 0..2 legal.
REQ-005 SHALL expose: cmd_len  input  6  payload byte count, 1..63 legal.
REQ-006 SHALL expose: cmd_bad_par  input  1  invert the transmitted parity byte (error injection).
REQ-007 SHALL expose: cmd_ready  output  1  command accepted on an edge where cmd_valid&cmd_ready.
REQ-008 SHALL expose: s_valid  input  1; s_data  input  8; s_ready  output  1  payload byte stream, byte taken on an edge where s_valid&s_ready.
REQ-009 SHALL expose: busy  input  1  router back-pressure.
REQ-010 SHALL expose: pkt_valid  output  1; data_out  output  8  router-side packet bus.
REQ-011 SHALL expose: cmd_err  output  1  one-cycle pulse, illegal command dropped.
REQ-012 SHALL expose: pkt_done  output  1  one-cycle pulse, parity byte taken by router.

Function
REQ-013 SHALL implement states IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
REQ-014 SHALL drive cmd_ready=1 only in IDLE; s_ready=1 only in LOAD while loaded count < latched len.
REQ-015 On command accept with cmd_dest=3 or cmd_len=0, SHALL pulse cmd_err next cycle and remain in IDLE.
REQ-016 On legal command accept, SHALL latch dest, len, bad_par and enter LOAD.
REQ-017 In LOAD, SHALL write each accepted s_data byte into the payload buffer; on the edge taking byte number len, SHALL enter HEADER.
REQ-018 Router transfer rule: a byte on data_out is consumed on an edge where busy=0; while busy=1, data_out and pkt_valid SHALL hold.
REQ-019 HEADER: data_out={len,dest}, pkt_valid=1; on consume enter PAYLOAD.
REQ-020 PAYLOAD: data_out=buffer bytes in load order, pkt_valid=1; advance one byte per consume; on consuming byte len enter PARITY.
REQ-021 PARITY: pkt_valid=0, data_out=XOR of header and all payload bytes, bit-inverted if bad_par latched; on consume pulse pkt_done, enter GAP.
REQ-022 GAP: pkt_valid=0, data_out=0 for exactly 2 cycles regardless of busy, then IDLE.
REQ-023 pkt_valid and data_out SHALL be registered; header SHALL appear the cycle after the last payload byte is accepted.
REQ-024 Parity accumulator SHALL be 8 bits, cleared on entry to HEADER, updated on each consume.
REQ-025 cmd_valid, s_valid outside their ready windows SHALL be ignored with no side effects.

Reset
REQ-026 rstn high at an edge SHALL force IDLE, pkt_valid=0, data_out=0, cmd_err=0, pkt_done=0, buffer pointers, counters and parity to 0.
REQ-027 Reset mid-packet SHALL abort it: no parity byte, no pkt_done; cmd_ready=1 the cycle after rstn falls.

Structure
REQ-028 State encoding, MAX_LEN=63 and GAP_CYCLES=2 SHALL live in the shared router package.
REQ-029 Payload storage SHALL be a sub-module router_pkt_buf: 64x8, single write and read port, write/read pointers clearable.

Verification
REQ-030 cmd dest=1 len=3, payload A1,B2,C3, busy=0 -> data_out 0D,A1,B2,C3 with pkt_valid=1, then parity 0D^A1^B2^C3=DD with pkt_valid=0, pkt_done pulse, 2 gap cycles.
REQ-031 Same packet, busy=1 for 4 cycles during byte B2 -> B2 held 5 cycles, sequence and parity unchanged.
REQ-032 cmd dest=3 len=5 -> cmd_err pulse, no s_ready, pkt_valid stays 0.
REQ-033 cmd_bad_par=1 on 30.-packet -> parity byte 22.
REQ-034 len=63 all bytes FF -> header FC, 63 FF bytes, parity FC^FF (odd count)=03.
REQ-035 rstn pulsed during payload byte 2 -> next cycle pkt_valid=0, data_out=00, cmd_ready=1, no pkt_done.
